// File: rtl/uart_frame_link.sv
// rtl/uart_frame_link.sv - UART framed matrix receiver and framed result transmitter
// The RX and TX halves run independently so a result can go out while a frame comes in.
module uart_frame_link #(
  parameter int         ROWS      = 16,
  parameter int         COLS      = 16,
  parameter logic [7:0] HDR       = 8'hAA,
  parameter logic [7:0] FTR       = 8'h55,
  parameter int         TIMEOUT   = 1_000_000,
  parameter int         RES_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   wr_en,
  output logic [15:0]            wr_addr,
  output logic [7:0]             wr_data,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  input  logic                   res_valid,
  input  logic [8*RES_BYTES-1:0] res_data,
  output logic                   res_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   led
);

  localparam int          P        = ROWS * COLS;
  localparam logic [15:0] LAST_IDX = 16'(P - 1);
  localparam int          GW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);
  localparam logic [4:0]  LAST_TX  = 5'(RES_BYTES + 2);

  typedef enum logic [1:0] {WAIT_HDR, RECV, WAIT_CKS, WAIT_FTR} rx_state_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} tx_state_t;

  rx_state_t      rx_state;
  logic [15:0]    index;
  logic [7:0]     sum;
  logic [GW-1:0]  gap;

  // Payload writes go out in the same cycle as the strobe.
  assign wr_en   = (rx_state == RECV) && rx_valid;
  assign wr_addr = index;
  assign wr_data = rx_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= WAIT_HDR;
      index      <= '0;
      sum        <= '0;
      gap        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      led        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state != WAIT_HDR) begin
        if (rx_valid) begin
          gap <= '0;
        end else if (gap == GAP_MAX) begin
          frame_err <= 1'b1;
          err_code  <= 2'd3;
          led       <= 1'b0;
          gap       <= '0;
          rx_state  <= WAIT_HDR;
        end else begin
          gap <= gap + 1'b1;
        end
      end
      if (rx_valid) begin
        case (rx_state)
          WAIT_HDR: begin
            if (rx_data == HDR) begin
              index    <= '0;
              sum      <= '0;
              gap      <= '0;
              rx_state <= RECV;
            end
          end
          RECV: begin
            index <= index + 16'd1;
            sum   <= sum + rx_data;
            if (index == LAST_IDX) rx_state <= WAIT_CKS;
          end
          WAIT_CKS: begin
            if (rx_data == sum) begin
              rx_state <= WAIT_FTR;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              led       <= 1'b0;
              rx_state  <= WAIT_HDR;
            end
          end
          WAIT_FTR: begin
            if (rx_data == FTR) begin
              frame_done <= 1'b1;
              led        <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              led       <= 1'b0;
            end
            rx_state <= WAIT_HDR;
          end
          default: rx_state <= WAIT_HDR;
        endcase
      end
    end
  end

  tx_state_t             tx_state;
  logic [4:0]            tx_idx;
  logic [8*RES_BYTES-1:0] res_q;
  logic [7:0]            tx_sum;
  logic [7:0]            cur_byte;

  always_comb begin
    tx_sum = 8'd0;
    for (int i = 0; i < RES_BYTES; i++) tx_sum = tx_sum + res_q[8*i +: 8];
  end

  // Outgoing byte order: header, result LSB-first, checksum, footer.
  always_comb begin
    cur_byte = HDR;
    for (int i = 0; i < RES_BYTES; i++) begin
      if (tx_idx == 5'(i + 1)) cur_byte = res_q[8*i +: 8];
    end
    if (tx_idx == 5'(RES_BYTES + 1)) cur_byte = tx_sum;
    if (tx_idx == LAST_TX) cur_byte = FTR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state  <= IDLE;
      tx_idx    <= '0;
      res_q     <= '0;
      res_ready <= 1'b1;
      tx_data   <= 8'd0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (res_valid && res_ready) begin
            res_q     <= res_data;
            tx_idx    <= '0;
            res_ready <= 1'b0;
            tx_state  <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            tx_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) tx_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (tx_idx == LAST_TX) begin
              res_ready <= 1'b1;
              tx_state  <= IDLE;
            end else begin
              tx_idx   <= tx_idx + 5'd1;
              tx_state <= SEND;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_link.sv
// tb/tb_uart_frame_link.sv - directed bench for uart_frame_link (2x2 matrix, short timeout)
module tb_uart_frame_link;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = 16'd0;
  logic        res_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        led;

  int checks = 0;
  int failures = 0;

  uart_frame_link #(.ROWS(2), .COLS(2), .HDR(8'hAA), .FTR(8'h55),
                    .TIMEOUT(100), .RES_BYTES(2)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .led(led)
  );

  always #5 clk = ~clk;

  // Write/pulse monitor, sampled on the falling edge.
  logic [15:0] wa [64];
  logic [7:0]  wd [64];
  int wn = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (wr_en === 1'b1 && wn < 64) begin
      wa[wn] = wr_addr;
      wd[wn] = wr_data;
      wn++;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  // Transmitter model: busy rises two cycles after start, holds four cycles.
  logic [7:0] txb [8];
  int tn = 0;
  int tx_viol = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        if (tx_busy !== 1'b0 || res_ready !== 1'b0) tx_viol++;
        if (tn < 8) txb[tn] = tx_data;
        tn++;
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, d1, d2, d3, cks, ftr);
    send_byte(8'hAA); send_byte(d0); send_byte(d1);
    send_byte(d2); send_byte(d3); send_byte(cks); send_byte(ftr);
    repeat (2) @(posedge clk);
  endtask

  int base;
  int d0, e0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led, 0);
    check("rst_err_code", err_code, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_res_ready", res_ready, 1);
    check("rst_pulses", done_cnt + err_cnt, 0);

    // Good frame: four writes, one done, led on.
    base = wn;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h55);
    check("good_nwr", wn - base, 4);
    for (int i = 0; i < 4; i++) begin
      check("good_addr", wa[base+i], i);
      check("good_data", wd[base+i], i + 1);
    end
    check("good_done", done_cnt, 1);
    check("good_err", err_cnt, 0);
    check("good_led", led, 1);

    // Bad checksum, then a correct frame.
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, 8'h55);
    check("cks_err", err_cnt, 1);
    check("cks_code", err_code, 1);
    check("cks_led", led, 0);
    check("cks_done", done_cnt, 1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h55);
    check("after_cks_done", done_cnt, 2);
    check("after_cks_led", led, 1);
    check("code_held", err_code, 1);

    // Bad footer.
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h00);
    check("ftr_err", err_cnt, 2);
    check("ftr_code", err_code, 2);
    check("ftr_done", done_cnt, 2);

    // Header/footer values inside the payload are data: AA+55+01+02 = 0x102 -> 02.
    base = wn;
    send_frame(8'hAA, 8'h55, 8'h01, 8'h02, 8'h02, 8'h55);
    check("hdrdata_done", done_cnt, 3);
    check("hdrdata_nwr", wn - base, 4);
    check("hdrdata_d0", wd[base], 8'hAA);
    check("hdrdata_d1", wd[base+1], 8'h55);

    // Inter-byte timeout of 100 idle cycles.
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (90) @(posedge clk);
    #1;
    check("to_early", err_cnt, 2);
    for (int i = 0; i < 30 && err_cnt == 2; i++) @(posedge clk);
    #1;
    check("to_err", err_cnt, 3);
    check("to_code", err_code, 3);
    send_byte(8'h77);
    repeat (2) @(posedge clk);
    check("stray_ignored", err_cnt + done_cnt, 6);
    base = wn;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h55);
    check("to_next_done", done_cnt, 4);
    check("to_next_addr0", wa[base], 0);

    // Reset mid-frame abandons it silently.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    check("rstmid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("rstmid_led", led, 0);
    base = wn;
    send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, 8'h55);
    check("rstmid_done", done_cnt - d0, 1);
    check("rstmid_addr0", wa[base], 0);
    check("rstmid_data0", wd[base], 8'h05);
    check("rstmid_addr3", wa[base+3], 3);

    // Result transmission: AA 34 12 46 55.
    res_data = 16'h1234;
    @(posedge clk); #1;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    res_data = 16'hFFFF;
    @(posedge clk); #1;
    check("tx_ready_low", res_ready, 0);
    for (int i = 0; i < 500 && !(tn >= 5 && res_ready === 1'b1); i++) @(posedge clk);
    #1;
    check("tx_count", tn, 5);
    check("tx_b0", txb[0], 8'hAA);
    check("tx_b1", txb[1], 8'h34);
    check("tx_b2", txb[2], 8'h12);
    check("tx_b3", txb[3], 8'h46);
    check("tx_b4", txb[4], 8'h55);
    check("tx_handshake", tx_viol, 0);
    check("tx_ready_back", res_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
